// File: rtl/arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
package arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor; master issues operands, slave computes.
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );

endinterface

// File: rtl/full_subtractor_behav.sv
// One-bit full subtractor: d = a - b - bin with borrow-out.
module full_subtractor_behav (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  always_comb begin
    d_o    = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (bin_i & ~(a_i ^ b_i));
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, one bit per clock, LSB first.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, d_q;
  logic [CntW-1:0]  cnt_q;
  logic             br_q, busy_q, done_q, bout_q;

  logic             diff_bit, br_d;
  logic [WIDTH-1:0] res_d;

  full_subtractor_behav u_fs (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (br_q),
    .d_o    (diff_bit),
    .bout_o (br_d)
  );

  // Result fills from the MSB so that after WIDTH shifts bit 0 holds the first diff bit.
  always_comb begin
    res_d            = res_q >> 1;
    res_d[WIDTH-1]   = diff_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            br_q    <= bus.bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            d_q     <= res_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sweep checks of serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one WIDTH=8 operation; lat counts negedges from start release to done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     output logic [7:0] d, output logic bo, output int lat, output int nbusy);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bi;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = 1; nbusy = 0;
    while (!bus8.done && lat < 20) begin
      if (bus8.busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    d = bus8.d; bo = bus8.bout;
  endtask

  task automatic op1(input logic a, input logic b, input logic bi,
                     output logic d, output logic bo, output int lat);
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.bin = bi;
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 1;
    while (!bus1.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    d = bus1.d; bo = bus1.bout;
  endtask

  initial begin
    logic [7:0] d;
    logic       bo, d1, bo1;
    int         lat, nbusy, ndone, first_done, last_done, unstable;
    logic [7:0] ra, rb;
    logic       rbi;
    logic [8:0] ref9;
    logic [1:0] ref2;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(bus8.busy), 32'd0);
    check_eq("rst_done", 32'(bus8.done), 32'd0);
    check_eq("rst_d", 32'(bus8.d), 32'd0);
    check_eq("rst_bout", 32'(bus8.bout), 32'd0);
    rst_n = 1'b1;

    // Basic operation with latency and busy duration.
    op8(8'h5A, 8'h23, 1'b0, d, bo, lat, nbusy);
    check_eq("t1_lat", 32'(lat), 32'd9);
    check_eq("t1_busy_cycles", 32'(nbusy), 32'd8);
    check_eq("t1_d", 32'(d), 32'h37);
    check_eq("t1_bout", 32'(bo), 32'd0);
    @(negedge clk);
    check_eq("t1_done_one_cycle", 32'(bus8.done), 32'd0);

    op8(8'h10, 8'h20, 1'b0, d, bo, lat, nbusy);
    check_eq("t2a_dbout", {23'd0, bo, d}, 32'h1F0);
    op8(8'h00, 8'h00, 1'b1, d, bo, lat, nbusy);
    check_eq("t2b_dbout", {23'd0, bo, d}, 32'h1FF);
    op8(8'hFF, 8'hFF, 1'b1, d, bo, lat, nbusy);
    check_eq("t2c_dbout", {23'd0, bo, d}, 32'h1FF);

    // start re-pulsed during SHIFT must be ignored.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h11; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    check_eq("t3_no_partial_d", 32'(bus8.d), 32'hFF);
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.bin = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    ndone = 0; first_done = 0;
    for (int i = 3; i <= 20; i++) begin
      if (bus8.done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = i;
          check_eq("t3_dbout", {23'd0, bus8.bout, bus8.d}, 32'h022);
        end
      end
      @(negedge clk);
    end
    check_eq("t3_done_count", 32'(ndone), 32'd1);
    check_eq("t3_done_lat", 32'(first_done), 32'd9);

    // start held high: one result every 9 cycles, d stable between pulses.
    bus8.start = 1'b1; bus8.a = 8'h80; bus8.b = 8'h01; bus8.bin = 1'b0;
    ndone = 0; first_done = 0; last_done = 0; unstable = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        ndone++;
        if (first_done == 0) first_done = i;
        last_done = i;
      end
      if (first_done != 0 && {bus8.bout, bus8.d} !== 9'h07F) unstable++;
    end
    bus8.start = 1'b0;
    check_eq("t4_done_count", 32'(ndone), 32'd3);
    check_eq("t4_first_done", 32'(first_done), 32'd9);
    check_eq("t4_last_done", 32'(last_done), 32'd27);
    check_eq("t4_d_unstable", 32'(unstable), 32'd0);
    repeat (12) @(negedge clk);

    // Asynchronous reset mid-operation.
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h23; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5_busy_before", 32'(bus8.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_busy", 32'(bus8.busy), 32'd0);
    check_eq("t5_rst_d", 32'(bus8.d), 32'd0);
    check_eq("t5_rst_bout", 32'(bus8.bout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) ndone++;
    end
    check_eq("t5_no_done", 32'(ndone), 32'd0);
    op8(8'h5A, 8'h23, 1'b0, d, bo, lat, nbusy);
    check_eq("t5_fresh_lat", 32'(lat), 32'd9);
    check_eq("t5_fresh_dbout", {23'd0, bo, d}, 32'h037);

    // Random sweep against a 9-bit reference.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbi = 1'($urandom_range(0, 1));
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      op8(ra, rb, rbi, d, bo, lat, nbusy);
      check_eq("rand_dbout", {23'd0, bo, d}, {23'd0, ref9});
    end

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      ref2 = {1'b0, v[2]} - {1'b0, v[1]} - {1'b0, v[0]};
      op1(v[2], v[1], v[0], d1, bo1, lat);
      check_eq("w1_lat", 32'(lat), 32'd2);
      check_eq("w1_dbout", {30'd0, bo1, d1}, {30'd0, ref2});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
